// File: rtl/test_phy_gen.sv
// test_phy_gen: loopback traffic generator and checker for MAC/PHY bring-up.
// The generator emits packets of incrementing or PRBS-31 beats. The checker
// compares the looped-back stream against its own pattern generator and keeps
// saturating statistics plus a sticky error flag.
module test_phy_gen #(
    parameter int TEST_DATA_WIDTH = 8,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [TEST_DATA_WIDTH-1:0] mac_tx_data,
    output logic                       mac_tx_valid,
    output logic                       mac_tx_sof,
    output logic                       mac_tx_eof,
    input  logic                       mac_tx_rdy,
    input  logic [TEST_DATA_WIDTH-1:0] mac_rx_data,
    input  logic                       mac_rx_valid,
    input  logic                       mac_rx_sof,
    input  logic                       mac_rx_eof,
    input  logic                       mac_rx_fr_good,
    input  logic                       mac_rx_fr_err,
    input  logic [15:0]                pkt_size,
    input  logic [15:0]                pause_size,
    input  logic                       mode,
    input  logic                       start,
    input  logic                       clr_stat,
    output logic                       err,
    output logic [TEST_DATA_WIDTH-1:0] test_data,
    output logic [STAT_WIDTH-1:0]      tx_pkt_cnt,
    output logic [STAT_WIDTH-1:0]      rx_good_cnt,
    output logic [STAT_WIDTH-1:0]      rx_bad_cnt,
    output logic [STAT_WIDTH-1:0]      mismatch_cnt
);
    localparam int W = TEST_DATA_WIDTH;
    localparam logic [30:0] LFSR_SEED = {31{1'b1}};
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // x^31 + x^28 + 1, shifting towards the MSB with the feedback entering at bit 0
    function automatic logic [30:0] lfsr_next(input logic [30:0] s);
        return {s[29:0], s[30] ^ s[27]};
    endfunction

    // Beat value: beat index or LFSR state, zero-extended to 32 bits then truncated
    function automatic logic [W-1:0] pattern(input logic m, input logic [15:0] k, input logic [30:0] s);
        return W'(m ? {1'b0, s} : {16'd0, k});
    endfunction

    // Saturating add used by every statistics counter
    function automatic logic [STAT_WIDTH-1:0] sat_add(input logic [STAT_WIDTH-1:0] c, input logic [1:0] inc);
        logic [STAT_WIDTH:0] sum;
        sum = {1'b0, c} + (STAT_WIDTH+1)'(inc);
        return sum[STAT_WIDTH] ? STAT_MAX : sum[STAT_WIDTH-1:0];
    endfunction

    state_t      state_r;
    logic [15:0] pkt_r;
    logic [15:0] pause_r;
    logic        mode_r;
    logic [15:0] beat_r;
    logic [15:0] pause_cnt_r;
    logic [30:0] tx_lfsr_r;
    logic        tx_fire_s;
    logic        tx_eof_fire_s;

    assign tx_fire_s     = mac_tx_valid && mac_tx_rdy;
    assign tx_eof_fire_s = tx_fire_s && mac_tx_eof;

    // Generator FSM with registered TX outputs; params are frozen on leaving IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pkt_r        <= 16'd0;
            pause_r      <= 16'd0;
            mode_r       <= 1'b0;
            beat_r       <= 16'd0;
            pause_cnt_r  <= 16'd0;
            tx_lfsr_r    <= LFSR_SEED;
            mac_tx_valid <= 1'b0;
            mac_tx_sof   <= 1'b0;
            mac_tx_eof   <= 1'b0;
            mac_tx_data  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && (pkt_size != 16'd0)) begin
                        pkt_r   <= pkt_size;
                        pause_r <= pause_size;
                        mode_r  <= mode;
                        state_r <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!mac_tx_valid) begin
                        // first beat of a packet launched from IDLE
                        mac_tx_valid <= 1'b1;
                        mac_tx_sof   <= 1'b1;
                        mac_tx_eof   <= (pkt_r == 16'd1);
                        mac_tx_data  <= pattern(mode_r, 16'd0, LFSR_SEED);
                        beat_r       <= 16'd0;
                        tx_lfsr_r    <= LFSR_SEED;
                    end else if (tx_fire_s) begin
                        if (mac_tx_eof) begin
                            if (!start) begin
                                state_r      <= ST_IDLE;
                                mac_tx_valid <= 1'b0;
                                mac_tx_sof   <= 1'b0;
                                mac_tx_eof   <= 1'b0;
                            end else if (pause_r != 16'd0) begin
                                state_r      <= ST_PAUSE;
                                pause_cnt_r  <= 16'd0;
                                mac_tx_valid <= 1'b0;
                                mac_tx_sof   <= 1'b0;
                                mac_tx_eof   <= 1'b0;
                            end else begin
                                // back-to-back: next packet's sof follows immediately
                                mac_tx_sof  <= 1'b1;
                                mac_tx_eof  <= (pkt_r == 16'd1);
                                mac_tx_data <= pattern(mode_r, 16'd0, LFSR_SEED);
                                beat_r      <= 16'd0;
                                tx_lfsr_r   <= LFSR_SEED;
                            end
                        end else begin
                            beat_r      <= beat_r + 16'd1;
                            tx_lfsr_r   <= lfsr_next(tx_lfsr_r);
                            mac_tx_data <= pattern(mode_r, beat_r + 16'd1, lfsr_next(tx_lfsr_r));
                            mac_tx_sof  <= 1'b0;
                            mac_tx_eof  <= (beat_r + 16'd2 == pkt_r);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_cnt_r == pause_r - 16'd1) begin
                        if (start) begin
                            // sof is presented right after the last idle cycle
                            state_r      <= ST_SEND;
                            mac_tx_valid <= 1'b1;
                            mac_tx_sof   <= 1'b1;
                            mac_tx_eof   <= (pkt_r == 16'd1);
                            mac_tx_data  <= pattern(mode_r, 16'd0, LFSR_SEED);
                            beat_r       <= 16'd0;
                            tx_lfsr_r    <= LFSR_SEED;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        pause_cnt_r <= pause_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    mac_tx_valid <= 1'b0;
                    mac_tx_sof   <= 1'b0;
                    mac_tx_eof   <= 1'b0;
                end
            endcase
        end
    end

    logic [15:0] rx_k_r;
    logic [30:0] rx_lfsr_r;
    logic        rx_in_pkt_r;
    logic        rx_data_bad_r;
    logic        rx_len_bad_r;
    logic [15:0] rx_k_s;
    logic [30:0] rx_lfsr_s;
    logic        data_bad_cur_s;
    logic        len_bad_cur_s;
    logic [W-1:0] rx_exp_s;
    logic        order_err_s;
    logic        data_err_s;
    logic        len_err_s;
    logic [1:0]  mm_inc_s;

    // Checker expectation for the current RX beat; sof restarts the pattern
    always_comb begin
        rx_k_s         = rx_k_r;
        rx_lfsr_s      = rx_lfsr_r;
        data_bad_cur_s = rx_data_bad_r;
        len_bad_cur_s  = rx_len_bad_r;
        if (mac_rx_sof) begin
            rx_k_s         = 16'd0;
            rx_lfsr_s      = LFSR_SEED;
            data_bad_cur_s = 1'b0;
            len_bad_cur_s  = 1'b0;
        end else begin
            rx_k_s         = rx_k_r;
            rx_lfsr_s      = rx_lfsr_r;
            data_bad_cur_s = rx_data_bad_r;
            len_bad_cur_s  = rx_len_bad_r;
        end
        rx_exp_s    = pattern(mode_r, rx_k_s, rx_lfsr_s);
        order_err_s = mac_rx_valid && mac_rx_sof && rx_in_pkt_r;
        data_err_s  = mac_rx_valid && (mac_rx_data != rx_exp_s) && !data_bad_cur_s;
        len_err_s   = mac_rx_valid && mac_rx_eof && (rx_k_s + 16'd1 != pkt_r) && !len_bad_cur_s;
        mm_inc_s    = {1'b0, order_err_s} + {1'b0, data_err_s} + {1'b0, len_err_s};
    end

    // Checker state advances only on valid RX beats
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_k_r        <= 16'd0;
            rx_lfsr_r     <= LFSR_SEED;
            rx_in_pkt_r   <= 1'b0;
            rx_data_bad_r <= 1'b0;
            rx_len_bad_r  <= 1'b0;
            test_data     <= '0;
        end else if (mac_rx_valid) begin
            rx_k_r        <= rx_k_s + 16'd1;
            rx_lfsr_r     <= lfsr_next(rx_lfsr_s);
            rx_in_pkt_r   <= !mac_rx_eof;
            rx_data_bad_r <= data_bad_cur_s || data_err_s;
            rx_len_bad_r  <= len_bad_cur_s || len_err_s;
            test_data     <= mac_rx_data;
        end
    end

    logic start_d_r;

    // Statistics counters and sticky error; clr_stat overrides any same-cycle event
    always_ff @(posedge clk) begin
        if (rst) begin
            start_d_r    <= 1'b0;
            err          <= 1'b0;
            tx_pkt_cnt   <= '0;
            rx_good_cnt  <= '0;
            rx_bad_cnt   <= '0;
            mismatch_cnt <= '0;
        end else begin
            start_d_r <= start;
            if (clr_stat) begin
                err          <= 1'b0;
                tx_pkt_cnt   <= '0;
                rx_good_cnt  <= '0;
                rx_bad_cnt   <= '0;
                mismatch_cnt <= '0;
            end else begin
                tx_pkt_cnt   <= sat_add(tx_pkt_cnt, {1'b0, tx_eof_fire_s});
                rx_good_cnt  <= sat_add(rx_good_cnt, {1'b0, mac_rx_fr_good});
                rx_bad_cnt   <= sat_add(rx_bad_cnt, {1'b0, mac_rx_fr_err});
                mismatch_cnt <= sat_add(mismatch_cnt, mm_inc_s);
                if ((mm_inc_s != 2'd0) || mac_rx_fr_err) begin
                    err <= 1'b1;
                end else if (start && !start_d_r) begin
                    err <= 1'b0;
                end else begin
                    err <= err;
                end
            end
        end
    end

endmodule

// File: tb/tb_test_phy_gen.sv
// tb_test_phy_gen: directed + randomized bench with an abstract reference model
// (PRBS as a bit sequence b[n] = b[n-31] ^ b[n-28]) and an external loopback.
module tb_test_phy_gen;
    localparam int W  = 8;
    localparam int SW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, mac_tx_valid, mac_tx_sof, mac_tx_eof, mac_tx_rdy;
    logic [W-1:0]  mac_tx_data, mac_rx_data, test_data;
    logic          mac_rx_valid, mac_rx_sof, mac_rx_eof, mac_rx_fr_good, mac_rx_fr_err;
    logic [15:0]   pkt_size, pause_size;
    logic          mode, start, clr_stat, err;
    logic [SW-1:0] tx_pkt_cnt, rx_good_cnt, rx_bad_cnt, mismatch_cnt;

    test_phy_gen #(.TEST_DATA_WIDTH(W), .STAT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid), .mac_tx_sof(mac_tx_sof),
        .mac_tx_eof(mac_tx_eof), .mac_tx_rdy(mac_tx_rdy),
        .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid), .mac_rx_sof(mac_rx_sof),
        .mac_rx_eof(mac_rx_eof), .mac_rx_fr_good(mac_rx_fr_good), .mac_rx_fr_err(mac_rx_fr_err),
        .pkt_size(pkt_size), .pause_size(pause_size), .mode(mode), .start(start),
        .clr_stat(clr_stat), .err(err), .test_data(test_data),
        .tx_pkt_cnt(tx_pkt_cnt), .rx_good_cnt(rx_good_cnt), .rx_bad_cnt(rx_bad_cnt),
        .mismatch_cnt(mismatch_cnt)
    );

    int tests = 0;
    int fails = 0;
    bit prbs_bits [0:255];

    // scoreboard / stimulus state
    int rdy_mode;
    bit loopback;
    int corrupt_pkt = -1;
    int corrupt_beat;
    int k_exp, pkts_sent, pkts_started, stop_after, gap;
    bit gap_armed;
    int cfg_pkt, cfg_pause;
    bit cfg_mode;
    bit pend_v, pend_sof, pend_eof, pend_bad;
    logic [W-1:0] pend_d;
    bit prev_stall, prev_sof, prev_eof;
    logic [W-1:0] prev_d;
    int exp_mm, exp_tx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beat value k of a packet, straight from the pattern definition
    function automatic logic [W-1:0] ref_word(input bit m, input int k);
        logic [W-1:0] w;
        w = '0;
        if (!m) begin
            w = W'(k);
        end else begin
            for (int i = 0; i < W; i++) w[i] = (i < 31) ? prbs_bits[k + 30 - i] : 1'b0;
        end
        return w;
    endfunction

    // One clock: drive rdy and looped-back RX, score TX, then advance to next negedge
    task automatic cycle();
        bit rx_drv, bad_drv, corrupt_now;
        logic [W-1:0] rx_val;
        case (rdy_mode)
            0:       mac_tx_rdy = 1'b1;
            1:       mac_tx_rdy = ~mac_tx_rdy;
            default: mac_tx_rdy = 1'($urandom_range(0, 1));
        endcase
        mac_rx_valid = pend_v; mac_rx_data = pend_d; mac_rx_sof = pend_sof; mac_rx_eof = pend_eof;
        rx_drv = pend_v; bad_drv = pend_bad; rx_val = pend_d; pend_v = 1'b0;
        if (prev_stall) begin
            check("tx_hold_valid", mac_tx_valid, 1'b1);
            check("tx_hold_data", mac_tx_data, prev_d);
            check("tx_hold_sof", mac_tx_sof, prev_sof);
            check("tx_hold_eof", mac_tx_eof, prev_eof);
        end
        if (mac_tx_valid && mac_tx_sof && gap_armed) begin
            check("tx_gap", gap, cfg_pause);
            gap_armed = 1'b0;
        end
        if (stop_after > 0 && mac_tx_valid && mac_tx_sof && pkts_started == stop_after - 1) start = 1'b0;
        if (mac_tx_valid && mac_tx_rdy) begin
            check("tx_data", mac_tx_data, ref_word(cfg_mode, k_exp));
            check("tx_sof", mac_tx_sof, k_exp == 0);
            check("tx_eof", mac_tx_eof, k_exp == cfg_pkt - 1);
            if (loopback) begin
                corrupt_now = (pkts_sent == corrupt_pkt) && (k_exp == corrupt_beat);
                pend_v = 1'b1; pend_sof = mac_tx_sof; pend_eof = mac_tx_eof; pend_bad = corrupt_now;
                pend_d = mac_tx_data ^ (corrupt_now ? W'(1) : W'(0));
            end
            if (k_exp == 0) pkts_started++;
            if (k_exp == cfg_pkt - 1) begin
                k_exp = 0; pkts_sent++; exp_tx++; gap = 0; gap_armed = 1'b1;
            end else begin
                k_exp++;
            end
        end else if (!mac_tx_valid) begin
            gap++;
        end
        prev_stall = mac_tx_valid && !mac_tx_rdy;
        prev_d = mac_tx_data; prev_sof = mac_tx_sof; prev_eof = mac_tx_eof;
        @(posedge clk);
        @(negedge clk);
        if (rx_drv) begin
            check("test_data", test_data, rx_val);
            if (bad_drv) begin
                exp_mm++;
                check("err_after_corrupt", err, 1'b1);
                check("mm_after_corrupt", mismatch_cnt, exp_mm);
            end
        end
        mac_rx_valid = 1'b0; mac_rx_sof = 1'b0; mac_rx_eof = 1'b0;
    endtask

    // Run the generator for n packets with start held, then confirm it goes quiet
    task automatic run_phase(input bit m, input int pkt, input int pause, input int rmode, input int n);
        cfg_mode = m; cfg_pkt = pkt; cfg_pause = pause; rdy_mode = rmode;
        mode = m; pkt_size = 16'(pkt); pause_size = 16'(pause);
        k_exp = 0; pkts_sent = 0; pkts_started = 0; stop_after = n; gap_armed = 1'b0; prev_stall = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 3000 && pkts_sent < n; c++) cycle();
        check("phase_pkts", pkts_sent, n);
        for (int c = 0; c < pause + 4; c++) begin
            check("idle_valid", mac_tx_valid, 1'b0);
            cycle();
        end
    endtask

    task automatic rx_beat(input logic [W-1:0] d, input bit s, input bit e, input bit v);
        mac_rx_data = d; mac_rx_sof = s; mac_rx_eof = e; mac_rx_valid = v;
        @(posedge clk);
        @(negedge clk);
        if (v) check("rx_test_data", test_data, d);
        mac_rx_valid = 1'b0; mac_rx_sof = 1'b0; mac_rx_eof = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, mac_tx_valid, 1'b0);
        check({tag, "_sof"}, mac_tx_sof, 1'b0);
        check({tag, "_eof"}, mac_tx_eof, 1'b0);
        check({tag, "_data"}, mac_tx_data, 0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_test_data"}, test_data, 0);
        check({tag, "_tx_cnt"}, tx_pkt_cnt, 0);
        check({tag, "_good_cnt"}, rx_good_cnt, 0);
        check({tag, "_bad_cnt"}, rx_bad_cnt, 0);
        check({tag, "_mm_cnt"}, mismatch_cnt, 0);
    endtask

    initial begin
        for (int n = 0; n < 256; n++) prbs_bits[n] = (n < 31) ? 1'b1 : (prbs_bits[n - 31] ^ prbs_bits[n - 28]);
        rst = 1'b1; mac_tx_rdy = 1'b1; mac_rx_data = '0; mac_rx_valid = 1'b0; mac_rx_sof = 1'b0;
        mac_rx_eof = 1'b0; mac_rx_fr_good = 1'b0; mac_rx_fr_err = 1'b0; pkt_size = 16'd0;
        pause_size = 16'd0; mode = 1'b0; start = 1'b0; clr_stat = 1'b0;
        loopback = 1'b1; pend_v = 1'b0; exp_mm = 0; exp_tx = 0; gap = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // 1: incrementing, 4 beats, 2 idle cycles, rdy always high
        run_phase(1'b0, 4, 2, 0, 3);
        check("p1_tx_cnt", tx_pkt_cnt, 3);
        check("p1_mm", mismatch_cnt, 0);
        check("p1_err", err, 1'b0);

        // 2: PRBS, 5 beats, rdy toggling
        run_phase(1'b1, 5, 2, 1, 2);
        check("p2_tx_cnt", tx_pkt_cnt, exp_tx);
        check("p2_mm", mismatch_cnt, 0);
        check("p2_err", err, 1'b0);

        // random configuration with random backpressure
        run_phase(1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom_range(0, 3), 2, 3);
        check("pr_tx_cnt", tx_pkt_cnt, exp_tx);
        check("pr_mm", mismatch_cnt, 0);

        // 3: corrupt beat 2 of packet 1
        corrupt_pkt = 1; corrupt_beat = 2;
        run_phase(1'b0, 4, 1, 2, 3);
        corrupt_pkt = -1;
        check("p3_mm", mismatch_cnt, exp_mm);
        check("p3_err", err, 1'b1);
        check("p3_tx_cnt", tx_pkt_cnt, exp_tx);

        // clear statistics
        clr_stat = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_stat = 1'b0;
        exp_mm = 0; exp_tx = 0;
        check("clr_tx", tx_pkt_cnt, 0);
        check("clr_mm", mismatch_cnt, 0);
        check("clr_err", err, 1'b0);

        // 4: short RX packet (3 of 4 beats) with an ignored invalid beat inside
        rx_beat(8'd0, 1'b1, 1'b0, 1'b1);
        rx_beat(8'hA5, 1'b1, 1'b1, 1'b0);
        rx_beat(8'd1, 1'b0, 1'b0, 1'b1);
        rx_beat(8'd2, 1'b0, 1'b1, 1'b1);
        check("p4_short_mm", mismatch_cnt, 1);
        check("p4_short_err", err, 1'b1);
        for (int i = 0; i < 4; i++) rx_beat(8'(i), i == 0, i == 3, 1'b1);
        check("p4_good_mm", mismatch_cnt, 1);
        // sof arriving before the previous packet's eof
        rx_beat(8'd0, 1'b1, 1'b0, 1'b1);
        rx_beat(8'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) rx_beat(8'(i), i == 0, i == 3, 1'b1);
        check("p4_order_mm", mismatch_cnt, 2);

        // 5: single-beat packets back to back; start edge clears err
        run_phase(1'b0, 1, 0, 0, 5);
        check("p5_tx_cnt", tx_pkt_cnt, 5);
        check("p5_err", err, 1'b0);
        check("p5_mm", mismatch_cnt, 2);
        mac_rx_fr_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mac_rx_fr_err = 1'b0;
        check("p5_bad_cnt", rx_bad_cnt, 1);
        check("p5_err_fr", err, 1'b1);
        mac_rx_fr_good = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("p5_good_cnt", rx_good_cnt, 1);

        // 6: clr_stat in the same cycle as fr_good
        clr_stat = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_stat = 1'b0; mac_rx_fr_good = 1'b0;
        check("p6_good", rx_good_cnt, 0);
        check("p6_bad", rx_bad_cnt, 0);
        check("p6_tx", tx_pkt_cnt, 0);
        check("p6_mm", mismatch_cnt, 0);
        check("p6_err", err, 1'b0);

        // 6: reset in the middle of a packet
        cfg_mode = 1'b0; cfg_pkt = 8; cfg_pause = 0; rdy_mode = 0;
        mode = 1'b0; pkt_size = 16'd8; pause_size = 16'd0;
        k_exp = 0; pkts_sent = 0; pkts_started = 0; stop_after = 0; gap_armed = 1'b0; prev_stall = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 50 && k_exp < 3; c++) cycle();
        check("p6_midpkt", k_exp, 3);
        check("p6_valid_before", mac_tx_valid, 1'b1);
        rst = 1'b1; start = 1'b0; pend_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            check("post_rst_valid", mac_tx_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/test_phy_gen.md
Name: test_phy_gen

Overview:
Parametrised loopback traffic generator and checker for MAC/PHY bring-up. It replaces the fixed counter-only tester with the following additions:
- selectable data pattern (incrementing or PRBS-31);
- checker-side length verification;
- saturating statistics counters;
- a sticky error flag that can be cleared.

It sits between the MAC user interface and the board control/status registers. The TX stream is looped back externally through the PHY.

Parameters:
TEST_DATA_WIDTH, 8, data beat width in bits; legal range 1..32.
STAT_WIDTH, 32, width of each statistics counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
mac_tx_data  output  TEST_DATA_WIDTH  TX beat data
mac_tx_valid  output  1  TX beat valid
mac_tx_sof  output  1  first beat of packet
mac_tx_eof  output  1  last beat of packet
mac_tx_rdy  input  1  MAC accepts beat
mac_rx_data  input  TEST_DATA_WIDTH  RX beat data
mac_rx_valid  input  1  RX beat valid
mac_rx_sof  input  1  RX first beat
mac_rx_eof  input  1  RX last beat
mac_rx_fr_good  input  1  one-cycle pulse: frame FCS good
mac_rx_fr_err  input  1  one-cycle pulse: frame FCS bad
pkt_size  input  16  packet length in beats
pause_size  input  16  idle cycles between packets
mode  input  1  0 = incrementing, 1 = PRBS-31
start  input  1  level; run generator while high
clr_stat  input  1  synchronous clear of counters and err
err  output  1  sticky checker error
test_data  output  TEST_DATA_WIDTH  last received RX beat
tx_pkt_cnt  output  STAT_WIDTH  packets sent
rx_good_cnt  output  STAT_WIDTH  fr_good pulses
rx_bad_cnt  output  STAT_WIDTH  fr_err pulses
mismatch_cnt  output  STAT_WIDTH  data or length mismatches

Behaviour:
- Reset: all outputs 0. Generator FSM goes to IDLE. Both LFSRs are set to all-ones.
- Beat transfer: a TX beat transfers when mac_tx_valid && mac_tx_rdy. While valid is high and rdy is low, data, sof and eof hold stable.
- Generator FSM, IDLE -> SEND:
  - Taken when start=1 and pkt_size!=0.
  - pkt_size, pause_size and mode are latched at this point and are stable for the whole packet.
  - mac_tx_valid rises in the cycle after entry to SEND.
- Generator FSM, SEND -> PAUSE or IDLE (on the accepted eof beat):
  - pause_size!=0 and start=1: go to PAUSE.
  - pause_size=0 and start=1: go back to SEND with no gap; the next sof is driven in the following cycle.
  - start=0: go to IDLE.
- Generator FSM, PAUSE -> SEND or IDLE:
  - PAUSE counts exactly pause_size cycles with valid=0, then re-enters SEND if start=1, else IDLE.
- start deassert mid-packet: the current packet completes. It is never truncated.
- pkt_size=1: sof and eof are asserted on the same beat.
- tx_pkt_cnt increments on each accepted eof beat.
- Data patterns (beat index k starts at 0 on each packet):
  - mode 0: data = k[TEST_DATA_WIDTH-1:0]; wraps modulo 2^TEST_DATA_WIDTH.
  - mode 1: 31-bit LFSR, polynomial x^31+x^28+1. Reloaded to all-ones at each sof. Stepped once per accepted beat. data = lfsr[TEST_DATA_WIDTH-1:0], taking bit 30 as the MSB if TEST_DATA_WIDTH=32, with zero-extension.
- Checker:
  - Uses its own expected-pattern generator and the latched mode and pkt_size. It restarts on each rx valid&&sof beat.
  - Each rx valid beat is compared to the expected value. test_data takes the beat one cycle later.
  - A beat mismatch sets err and increments mismatch_cnt, at most once per packet.
  - A length mismatch also sets err and counts one mismatch, at most once per packet. It fires when eof arrives with beat count != pkt_size, or when sof arrives before the previous packet's eof.
  - Beats with valid=0 are ignored.
- Statistics:
  - rx_good_cnt and rx_bad_cnt increment on their respective pulses. fr_err also sets err.
  - All counters saturate at all-ones.
  - Counter and err updates are registered, with 1-cycle latency from the causing input.
- Clearing:
  - clr_stat=1 zeroes all counters and err in the next cycle. If a count event occurs in the same cycle, the clear wins.
  - A rising edge of start also clears err, but not the counters.
- rst asserted mid-packet: TX deasserts valid in the next cycle. No eof is emitted for the aborted packet.

Test Plan:
1. Loopback, mode=0, pkt_size=4, pause_size=2, rdy=1, start held high for 3 packets -> TX data 0,1,2,3 with sof on 0 and eof on 3, 2 idle cycles between packets; tx_pkt_cnt=3, mismatch_cnt=0, err=0.
2. mode=1, pkt_size=5, TEST_DATA_WIDTH=8, rdy toggled 1/0 every cycle -> beat values are the PRBS-31 sequence from the all-ones seed, stable during rdy=0; checker reports mismatch_cnt=0.
3. Corrupt RX beat 2 (XOR 0x01) in one packet -> err=1 one cycle later, mismatch_cnt=1; test_data equals the corrupted value.
4. RX packet of 3 beats with pkt_size=4 -> mismatch_cnt increments by 1 and err=1; a following correct packet does not increment mismatch_cnt.
5. pkt_size=1, pause_size=0 -> every beat has sof=eof=1, back-to-back; start dropped -> valid=0 after the current beat; fr_err pulse -> rx_bad_cnt=1, err=1.
6. clr_stat asserted in the same cycle as an fr_good pulse -> all counters read 0 and err=0 afterwards; rst asserted mid-packet -> valid=0 next cycle and all outputs 0.
